// File: rtl/sram_bus_bridge_if.sv
// rtl/sram_bus_bridge_if.sv - CPU bus controls, user port and commit signals of the SRAM bridge
interface sram_bus_bridge_if #(
    parameter int DW    = 16,
    parameter int AW    = 10,
    parameter int CNT_W = 16
) ();
    logic [AW-1:0]     bus_addr;
    logic              ncs;
    logic              nwe;
    logic              noe;
    logic [DW/8-1:0]   nbe;
    logic [AW-1:0]     usr_addr;
    logic              usr_we;
    logic [DW-1:0]     usr_wdata;
    logic [DW-1:0]     usr_rdata;
    logic              cpu_wr_strobe;
    logic [AW-1:0]     cpu_wr_addr;
    logic [CNT_W-1:0]  wr_count;

    modport master (
        output bus_addr, ncs, nwe, noe, nbe, usr_addr, usr_we, usr_wdata,
        input  usr_rdata, cpu_wr_strobe, cpu_wr_addr, wr_count
    );

    modport slave (
        input  bus_addr, ncs, nwe, noe, nbe, usr_addr, usr_we, usr_wdata,
        output usr_rdata, cpu_wr_strobe, cpu_wr_addr, wr_count
    );
endinterface

// File: rtl/sram_bus_bridge.sv
// rtl/sram_bus_bridge.sv - AT91 static-memory bus to dual-port block RAM bridge with write commit signalling
module sram_bus_bridge #(
    parameter int DW          = 16,
    parameter int AW          = 10,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic            clk,
    input  logic            reset,
    inout  wire  [DW-1:0]   bus_data,
    sram_bus_bridge_if.slave bus
);
    localparam int NB = DW / 8;

    typedef enum logic [1:0] {ARM, IDLE, ACTIVE} state_t;

    logic [SYNC_STAGES-1:0] ncs_q;
    logic [SYNC_STAGES-1:0] nwe_q;
    logic [NB-1:0]          nbe_q  [SYNC_STAGES];
    logic [AW-1:0]          addr_q [SYNC_STAGES];
    logic [DW-1:0]          data_q [SYNC_STAGES];

    logic          sncs;
    logic          snwe;
    logic [NB-1:0] sbe;
    logic [AW-1:0] saddr;
    logic [DW-1:0] sdata;

    state_t        state;
    state_t        state_nxt;
    logic          commit;
    logic          cpu_we;

    logic [DW-1:0] cap_data;
    logic [AW-1:0] cap_addr;
    logic [NB-1:0] cap_be;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] rdata_a;

    // Synchronisers run through reset so a bus cycle in flight at release is seen as busy.
    always_ff @(posedge clk) begin
        ncs_q     <= {ncs_q[SYNC_STAGES-2:0], bus.ncs};
        nwe_q     <= {nwe_q[SYNC_STAGES-2:0], bus.nwe};
        nbe_q[0]  <= bus.nbe;
        addr_q[0] <= bus.bus_addr;
        data_q[0] <= bus_data;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            nbe_q[i]  <= nbe_q[i-1];
            addr_q[i] <= addr_q[i-1];
            data_q[i] <= data_q[i-1];
        end
    end

    assign sncs  = ncs_q[SYNC_STAGES-1];
    assign snwe  = nwe_q[SYNC_STAGES-1];
    assign sbe   = ~nbe_q[SYNC_STAGES-1];
    assign saddr = addr_q[SYNC_STAGES-1];
    assign sdata = data_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) state <= ARM;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        commit    = 1'b0;
        case (state)
            ARM:     if (sncs | snwe) state_nxt = IDLE;
            IDLE:    if (!(sncs | snwe)) state_nxt = ACTIVE;
            ACTIVE:  if (sncs | snwe) begin
                         state_nxt = IDLE;
                         commit    = 1'b1;
                     end
            default: state_nxt = ARM;
        endcase
    end

    assign cpu_we = commit & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            cap_data <= '0;
            cap_addr <= '0;
            cap_be   <= '0;
        end else if (state == ACTIVE) begin
            cap_data <= sdata;
            cap_addr <= saddr;
            cap_be   <= sbe;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.cpu_wr_strobe <= 1'b0;
            bus.cpu_wr_addr   <= '0;
            bus.wr_count      <= '0;
        end else begin
            bus.cpu_wr_strobe <= cpu_we;
            if (cpu_we) begin
                bus.cpu_wr_addr <= cap_addr;
                bus.wr_count    <= bus.wr_count + CNT_W'(1);
            end
        end
    end

    // CPU byte writes are applied after the user write so CPU-enabled bytes win a same-address collision.
    always_ff @(posedge clk) begin
        if (bus.usr_we) mem[bus.usr_addr] <= bus.usr_wdata;
        if (cpu_we) begin
            for (int i = 0; i < NB; i++) begin
                if (cap_be[i]) mem[cap_addr][8*i +: 8] <= cap_data[8*i +: 8];
            end
        end
        rdata_a <= mem[saddr];
    end

    always_ff @(posedge clk) begin
        if (reset) bus.usr_rdata <= '0;
        else       bus.usr_rdata <= mem[bus.usr_addr];
    end

    assign bus_data = (!bus.ncs && !bus.noe && bus.nwe) ? rdata_a : {DW{1'bz}};
endmodule

// File: doc/sram_bus_bridge.md
Name: sram_bus_bridge

Overview:
Parametrised bridge between the AT91 static-memory bus and an internal dual-port block RAM. The CPU side has byte-lane writes and a tristated read path. A second, fully synchronous user port gives FPGA fabric logic access to the same RAM. The bridge also signals every committed CPU write to the fabric, as a strobe plus a wrapping write counter.

Parameters:
DW, 16, data width in bits; multiple of 8.
AW, 10, word address width; RAM depth = 2**AW words.
SYNC_STAGES, 2, flip-flop stages on the bus inputs; minimum 2.
CNT_W, 16, width of the committed-write counter.

Ports:
clk  in  1  system clock; all logic on the rising edge.
reset  in  1  synchronous, active-high.
bus_data  inout  DW  CPU data bus.
bus_addr  in  AW  CPU word address.
ncs  in  1  chip select, active low.
nwe  in  1  write enable, active low.
noe  in  1  output enable, active low.
nbe  in  DW/8  byte enables, active low; bit i gates bus_data[8i+7:8i].
usr_addr  in  AW  user-port address.
usr_we  in  1  user-port write enable.
usr_wdata  in  DW  user-port write data.
usr_rdata  out  DW  user-port read data.
cpu_wr_strobe  out  1  one-cycle pulse per committed CPU write.
cpu_wr_addr  out  AW  address of the last committed CPU write.
wr_count  out  CNT_W  count of committed CPU writes.

Behaviour:
- Interface: reset is synchronous, active-high; clock is clk.

Bus drive
- bus_data is driven with the port-A read data only when ncs=0, noe=0 and nwe=1. This is combinational from the raw pins; the bus is Z otherwise.

Input synchronisation
- ncs, nwe, nbe, bus_addr and bus_data each pass through SYNC_STAGES registers.
- Synchronised controls, address and data stay cycle-aligned; call them sncs, snwe, sbe, saddr, sdata.
- No negedge logic anywhere.

RAM
- Inferred true dual-port RAM, 2**AW x DW, with per-byte write enables.
- Contents are not reset.
- Port A (CPU): address = saddr in every cycle.
- Port B (user): address = usr_addr.
- Read latency of 1 cycle on both ports, read-first.
- Bus read latency from the pin address to bus_data = SYNC_STAGES+1 clk. The CPU NRD setup+pulse must be at least SYNC_STAGES+3 clk.

Write FSM (states ARM, IDLE, ACTIVE)
- Reset state: ARM.
- ARM -> IDLE when (sncs|snwe)=1. This means a write already in progress at reset release is never committed.
- IDLE -> ACTIVE when (sncs|snwe)=0.
- In ACTIVE, every cycle latches sdata, saddr and ~sbe into capture registers.
- ACTIVE -> IDLE when (sncs|snwe)=1. On that transition, in the same cycle, a port-A write of the captured data is issued with its byte mask.
- A byte mask of all zeros still counts as a commit but writes no bytes.
- The CPU must hold data for SYNC_STAGES+1 clk before nwe rises, and the NWE pulse must be at least SYNC_STAGES+2 clk.

Commit signalling
- cpu_wr_strobe pulses 1 in the cycle after the RAM write.
- cpu_wr_addr updates in that same cycle.
- wr_count increments in that same cycle and wraps from 2**CNT_W-1 to 0.

Collisions
- If both ports write the same address in the same cycle, the CPU data wins on the bytes it enables; user data fills the remaining bytes.
- A read on one port of an address being written on the other returns the old data.

Reset values
- cpu_wr_strobe=0, cpu_wr_addr=0, wr_count=0, usr_rdata=0, FSM=ARM, capture registers=0.
- Reset in the middle of a write aborts the write with no RAM update.

Test Plan:
- CPU write of 0xBEEF to address 0x005, nbe=00, NWE pulse 6 clk -> one cpu_wr_strobe pulse, cpu_wr_addr=0x005, wr_count=1; user read of 0x005 returns 0xBEEF 1 clk after usr_addr is applied.
- Byte write of 0x12xx to address 0x005 with nbe=01 over 0xBEEF -> RAM word becomes 0x12EF; a CPU read with ncs=0, noe=0 drives 0x12EF on bus_data by SYNC_STAGES+1 clk; bus_data is Z once noe=1.
- reset asserted while ncs=0 and nwe=0, then released with the bus still active -> no RAM write and no strobe; after ncs goes high and the next write completes, wr_count=1.
- Same-cycle writes to address 0x3FF: CPU 0xAAAA with nbe=10, user 0x5555 -> RAM holds 0x55AA.
- Write counter wrap: preload wr_count=0xFFFF (or use a bench with CNT_W=4 and 16 writes) -> next commit gives wr_count=0.
- 100 back-to-back CPU writes at random addresses, with ncs held low and only nwe toggling -> 100 strobes; RAM contents match the reference model.
